// File: rtl/preset_reg_driver.sv
// Command-side driver for a sync-preset register: one-cycle control strobes, readback, compare.
// Optional PRESET_DRV_ERRCNT_EN adds a saturating mismatch counter output err_count.
module preset_reg_driver #(
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             reg_enable,
  output logic             reg_sync_preset,
  output logic             reg_sync_rst,
  output logic [WIDTH-1:0] reg_data_in,
  input  logic [WIDTH-1:0] reg_data_out
`ifdef PRESET_DRV_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

  localparam logic [1:0] OP_HOLD   = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_PRESET = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             mismatch;
  logic [WIDTH-1:0] exp_p0;
  logic [WIDTH-1:0] mirror_q;

  function automatic logic [WIDTH-1:0] expected_value(input logic [1:0] op,
                                                      input logic [WIDTH-1:0] data,
                                                      input logic [WIDTH-1:0] mirror);
    logic [WIDTH-1:0] v;
    case (op)
      OP_LOAD:   v = data;
      OP_PRESET: v = PRESET_VALUE;
      OP_CLEAR:  v = '0;
      default:   v = mirror;
    endcase
    return v;
  endfunction

  assign accept   = (state_q == IDLE) && cmd_valid && cmd_ready;
  assign mismatch = (reg_data_out != exp_p0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE:   state_d = SAMPLE;
      SAMPLE:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accept edge: latch expectation and launch the strobe for the DRIVE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      reg_enable      <= 1'b0;
      reg_sync_preset <= 1'b0;
      reg_sync_rst    <= 1'b0;
      reg_data_in     <= '0;
      exp_p0          <= '0;
      mirror_q        <= '0;
    end else begin
      state_q         <= state_d;
      cmd_ready       <= (state_d == IDLE);
      rsp_valid       <= (state_d == RESP);
      reg_enable      <= accept && (cmd_op == OP_LOAD);
      reg_sync_preset <= accept && (cmd_op == OP_PRESET);
      reg_sync_rst    <= accept && (cmd_op == OP_CLEAR);
      reg_data_in     <= (accept && (cmd_op == OP_LOAD)) ? cmd_data : '0;
      if (accept)
        exp_p0 <= expected_value(cmd_op, cmd_data, mirror_q);
      // Sample edge: the register has settled one cycle after the strobe
      if (state_q == SAMPLE) begin
        rsp_data <= reg_data_out;
        rsp_err  <= mismatch;
        mirror_q <= reg_data_out;  // resync so one mismatch does not poison later HOLDs
      end
    end
  end

`ifdef PRESET_DRV_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if (accept && (cmd_op == OP_CLEAR))
      err_count <= 8'd0;
    else if ((state_q == SAMPLE) && mismatch && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_preset_reg_driver.sv
// Directed bench for preset_reg_driver with a behavioural sync-preset register attached.
module tb_preset_reg_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       reg_enable;
  logic       reg_sync_preset;
  logic       reg_sync_rst;
  logic [7:0] reg_data_in;
  logic [7:0] reg_data_out;
`ifdef PRESET_DRV_ERRCNT_EN
  logic [7:0] err_count;
`endif

  logic [7:0] reg_q;
  logic       force_en;
  logic [7:0] force_val;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  preset_reg_driver #(.WIDTH(8), .PRESET_VALUE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .reg_enable(reg_enable), .reg_sync_preset(reg_sync_preset), .reg_sync_rst(reg_sync_rst),
    .reg_data_in(reg_data_in), .reg_data_out(reg_data_out)
`ifdef PRESET_DRV_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  // Downstream register model sharing rst_n; force_en lets a test corrupt the readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               reg_q <= 8'h00;
    else if (reg_sync_rst)    reg_q <= 8'h00;
    else if (reg_sync_preset) reg_q <= 8'hFF;
    else if (reg_enable)      reg_q <= reg_data_in;
  end
  assign reg_data_out = force_en ? force_val : reg_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Full command with rsp_ready high; checks every cycle of the 4-cycle transaction
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                         input logic [7:0] exp_data, input logic exp_err);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    wait_ready(tag);
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_strobes"}, {reg_enable, reg_sync_preset, reg_sync_rst},
          {op == 2'd1, op == 2'd2, op == 2'd3});
    check({tag, "_data_in"}, reg_data_in, (op == 2'd1) ? data : 8'h00);
    check({tag, "_drive_nrdy"}, cmd_ready, 0);
    @(negedge clk);
    check({tag, "_sample_quiet"}, {reg_enable, reg_sync_preset, reg_sync_rst, rsp_valid}, 0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_data"}, rsp_data, exp_data);
    check({tag, "_rsp_err"}, rsp_err, exp_err);
    @(negedge clk);
    check({tag, "_rsp_drop"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen_rsp;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;
    rsp_ready = 1'b1; force_en = 1'b0; force_val = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_err, reg_enable,
                            reg_sync_preset, reg_sync_rst, reg_data_in}, 0);
`ifdef PRESET_DRV_ERRCNT_EN
    check("reset_errcnt", err_count, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    run_cmd("load_a5", 2'd1, 8'hA5, 8'hA5, 1'b0);
    run_cmd("preset", 2'd2, 8'h5A, 8'hFF, 1'b0);
    run_cmd("clear", 2'd3, 8'h5A, 8'h00, 1'b0);
    run_cmd("load_3c", 2'd1, 8'h3C, 8'h3C, 1'b0);
    run_cmd("hold", 2'd0, 8'hEE, 8'h3C, 1'b0);

    force_en = 1'b1; force_val = 8'h00;
    run_cmd("load_81_forced", 2'd1, 8'h81, 8'h00, 1'b1);
    force_en = 1'b0;
`ifdef PRESET_DRV_ERRCNT_EN
    check("errcnt_one", err_count, 1);
`endif
    // mirror resynced to the forced 0x00, register really holds 0x81
    run_cmd("hold_after_err", 2'd0, 8'h00, 8'h81, 1'b1);
`ifdef PRESET_DRV_ERRCNT_EN
    check("errcnt_two", err_count, 2);
`endif
    run_cmd("clear_after_err", 2'd3, 8'h00, 8'h00, 1'b0);
`ifdef PRESET_DRV_ERRCNT_EN
    check("errcnt_cleared", err_count, 0);
`endif

    // Backpressure with the next command held on the port
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'h55;
    wait_ready("bp");
    @(negedge clk);
    cmd_op = 2'd2; cmd_data = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stall", {cmd_ready, rsp_valid, rsp_data, rsp_err}, {1'b0, 1'b1, 8'h55, 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {rsp_valid, cmd_ready}, 2'b01);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_next_preset", {reg_enable, reg_sync_preset, reg_sync_rst}, 3'b010);
    repeat (2) @(negedge clk);
    check("bp_next_rsp", {rsp_valid, rsp_data, rsp_err}, {1'b1, 8'hFF, 1'b0});
    @(negedge clk);

    // Reset during DRIVE
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'h77;
    wait_ready("rst_mid");
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_mid_strobe", reg_enable, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_drop", {reg_enable, reg_sync_preset, reg_sync_rst, rsp_valid, cmd_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_rsp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    check("rst_mid_no_rsp", seen_rsp, 0);
    run_cmd("hold_post_rst", 2'd0, 8'h00, 8'h00, 1'b0);
    run_cmd("load_11", 2'd1, 8'h11, 8'h11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
